// File: rtl/imm_pkg.sv
// imm_pkg
// Shared types and constants for the LEGv8 immediate generator.
//   fmt_e     : format tag carried alongside every decoded immediate
//   OP_*      : opcode patterns, each sized to the instruction bits it matches
//   imm_res_t : one decoded result (immediate, format tag, illegal flag)
// The immediate field of imm_res_t is sized for the widest legal datapath
// (64 bits). Narrower instances use the low N bits, and the upper bits are
// always zero.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_I    = 3'd2,
    FMT_CB   = 3'd3,
    FMT_B    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_e;

  localparam int IMM_MAX_W = 64;

  // D-format loads/stores, matched on [31:21]
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CB-format conditional branches, matched on [31:24]
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  // B-format unconditional branches, matched on [31:26]
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  // I-format arithmetic, matched on [31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  // IW-format wide move, matched on [31:23]
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    fmt_e                 fmt;
    logic                 illegal;
  } imm_res_t;

endpackage : imm_pkg

// File: rtl/imm_decode.sv
// imm_decode
// Purely combinational decoder that turns a raw LEGv8 instruction word
// into an extended immediate, a format tag and an illegal-opcode flag.
// Ports:
//   instr : 32-bit raw instruction word
//   res   : decoded result; res.imm holds the N-bit immediate zero-padded
//           to the package-wide immediate width
// Parameter N selects the datapath width (32 or 64).
module imm_decode
  import imm_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [31:0] instr,
  output imm_res_t    res
);

  logic [N-1:0] d_imm;
  logic [N-1:0] cb_imm;
  logic [N-1:0] b_imm;
  logic [N-1:0] i_imm;
  logic [N-1:0] iw_base;
  logic [N-1:0] iw_imm;
  logic [6:0]   iw_shamt;
  logic         iw_oob;
  logic         unused_rt;

  // The Rt/Rd field never contributes to an immediate
  assign unused_rt = ^instr[4:0];

  // Every candidate extension is formed at width N. The opcode match
  // below picks one of them.
  assign d_imm   = {{(N-9){instr[20]}}, instr[20:12]};
  assign cb_imm  = {{(N-21){instr[23]}}, instr[23:5], 2'b00};
  assign b_imm   = {{(N-28){instr[25]}}, instr[25:0], 2'b00};
  assign i_imm   = {{(N-12){1'b0}}, instr[21:10]};
  assign iw_base = {{(N-16){1'b0}}, instr[20:5]};

  // The MOVZ shift is 16 * hw. Bits pushed past N simply fall off the top.
  assign iw_shamt = {1'b0, instr[22:21], 4'b0000};
  assign iw_imm   = iw_base << iw_shamt;

  // A shift that places the whole field beyond the datapath
  // (hw >= 2 on a 32-bit core) cannot be represented.
  assign iw_oob   = (int'(iw_shamt) >= N);

  // Priority match: the first opcode family that fits wins
  always_comb begin
    res.imm     = '0;
    res.fmt     = FMT_NONE;
    res.illegal = 1'b1;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      res.imm     = IMM_MAX_W'(d_imm);
      res.fmt     = FMT_D;
      res.illegal = 1'b0;
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      res.imm     = IMM_MAX_W'(cb_imm);
      res.fmt     = FMT_CB;
      res.illegal = 1'b0;
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      res.imm     = IMM_MAX_W'(b_imm);
      res.fmt     = FMT_B;
      res.illegal = 1'b0;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      res.imm     = IMM_MAX_W'(i_imm);
      res.fmt     = FMT_I;
      res.illegal = 1'b0;
    end else if (instr[31:23] == OP_MOVZ) begin
      res.fmt = FMT_IW;
      if (iw_oob) begin
        res.imm     = '0;
        res.illegal = 1'b1;
      end else begin
        res.imm     = IMM_MAX_W'(iw_imm);
        res.illegal = 1'b0;
      end
    end
  end

endmodule : imm_decode

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Registered immediate generator stage. It decodes the instruction, then
// passes the result through an output register backed by a one-entry skid
// register, which gives a two-deep, strictly ordered valid/ready stage.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake; in_ready is registered
//   in_instr              : raw 32-bit instruction
//   out_valid/out_ready   : downstream handshake
//   out_imm/out_fmt/out_illegal : decoded result held until accepted
//   err_count             : saturating count of accepted illegal words
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int N     = 64,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_imm,
  output fmt_e             out_fmt,
  output logic             out_illegal,
  output logic [ERR_W-1:0] err_count
);

  localparam imm_res_t RES_RESET = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

  imm_res_t         dec_res;
  imm_res_t         out_res_d,    out_res_q;
  imm_res_t         skid_res_d,   skid_res_q;
  logic             out_valid_d,  out_valid_q;
  logic             skid_valid_d, skid_valid_q;
  logic             in_ready_d,   in_ready_q;
  logic [ERR_W-1:0] err_count_d,  err_count_q;
  logic             accept;
  logic             out_free;

  imm_decode #(.N(N)) u_decode (
    .instr (in_instr),
    .res   (dec_res)
  );

  assign accept   = in_valid & in_ready_q;
  // The output register can take a new word if it is empty or its current
  // word leaves on this edge
  assign out_free = ~out_valid_q | out_ready;

  // Buffer steering. in_ready mirrors "skid empty", so a word is never
  // accepted while the skid is full. When the output frees up, the skid
  // entry always goes first, and a new word goes straight to the output
  // only when the skid is empty.
  always_comb begin
    out_res_d    = out_res_q;
    out_valid_d  = out_valid_q;
    skid_res_d   = skid_res_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_res_d    = skid_res_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_res_d   = dec_res;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_res_d   = dec_res;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Count illegal words as they are accepted, stopping at all-ones
  always_comb begin
    err_count_d = err_count_q;
    if (accept && dec_res.illegal && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_res_q    <= RES_RESET;
      out_valid_q  <= 1'b0;
      skid_res_q   <= RES_RESET;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      err_count_q  <= '0;
    end else begin
      out_res_q    <= out_res_d;
      out_valid_q  <= out_valid_d;
      skid_res_q   <= skid_res_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_res_q.imm[N-1:0];
  assign out_fmt     = out_res_q.fmt;
  assign out_illegal = out_res_q.illegal;
  assign err_count   = err_count_q;

endmodule : imm_gen_pipe

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
// Drives a 64-bit and a 32-bit instance with the same stimulus. A reference
// model runs alongside them: a two-entry queue of accepted instruction words,
// decoded arithmetically when checked.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  fmt_e        out_fmt64;
  logic [7:0]  err_count64;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  fmt_e        out_fmt32;
  logic [7:0]  err_count32;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.N(64), .ERR_W(8)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
    .err_count(err_count64)
  );

  imm_gen_pipe #(.N(32), .ERR_W(8)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32),
    .err_count(err_count32)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic ready);
    in_instr  = instr;
    in_valid  = valid;
    out_ready = ready;
  endtask

  // Arithmetic reference decode: signed integer ranges, then truncation to n bits
  function automatic void ref_decode(input logic [31:0] w, input int n,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint v;
    int     hw;
    v = 0; fmt = 3'd0; ill = 1'b0;
    if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
      v = longint'(w[20:12]);
      if (v > 255) v = v - 512;
      fmt = 3'd1;
    end else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101) begin
      v = longint'(w[23:5]) * 4;
      if (w[23]) v = v - (longint'(1) << 21);
      fmt = 3'd3;
    end else if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
      v = longint'(w[25:0]) * 4;
      if (w[25]) v = v - (longint'(1) << 28);
      fmt = 3'd4;
    end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
      v = longint'(w[21:10]);
      fmt = 3'd2;
    end else if (w[31:23] == 9'b110100101) begin
      hw = int'(w[22:21]);
      fmt = 3'd5;
      if (16 * hw >= n) ill = 1'b1;
      else v = longint'(w[20:5]) << (16 * hw);
    end else begin
      ill = 1'b1;
    end
    imm = (n == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[31:21] = $urandom_range(0, 1) ? 11'b11111000010 : 11'b11111000000;
      1: w[31:24] = $urandom_range(0, 1) ? 8'b10110100 : 8'b10110101;
      2: w[31:26] = $urandom_range(0, 1) ? 6'b000101 : 6'b100101;
      3: w[31:22] = $urandom_range(0, 1) ? 10'b1001000100 : 10'b1101000100;
      4, 5: w[31:23] = 9'b110100101;
      default: ;
    endcase
    return w;
  endfunction

  // Reference model: a queue holding at most two accepted words
  logic [31:0] mq[$];
  int          err64_m = 0;
  int          err32_m = 0;
  logic [63:0] m_imm;
  logic [2:0]  m_fmt;
  logic        m_ill64, m_ill32;
  bit          m_acc, m_drn;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      err64_m = 0;
      err32_m = 0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_drn = (mq.size() > 0) && out_ready;
      ref_decode(in_instr, 64, m_imm, m_fmt, m_ill64);
      ref_decode(in_instr, 32, m_imm, m_fmt, m_ill32);
      if (m_drn) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back(in_instr);
        if (m_ill64 && err64_m < 255) err64_m++;
        if (m_ill32 && err32_m < 255) err32_m++;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  logic [63:0] c_imm;
  logic [2:0]  c_fmt;
  logic        c_ill;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("in_ready64", 64'(in_ready64), 64'(mq.size() < 2));
      checkOutput("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
      checkOutput("out_valid64", 64'(out_valid64), 64'(mq.size() > 0));
      checkOutput("out_valid32", 64'(out_valid32), 64'(mq.size() > 0));
      checkOutput("err_count64", 64'(err_count64), 64'(err64_m));
      checkOutput("err_count32", 64'(err_count32), 64'(err32_m));
      if (mq.size() > 0) begin
        ref_decode(mq[0], 64, c_imm, c_fmt, c_ill);
        checkOutput("out_imm64", out_imm64, c_imm);
        checkOutput("out_fmt64", 64'(out_fmt64), 64'(c_fmt));
        checkOutput("out_illegal64", 64'(out_illegal64), 64'(c_ill));
        ref_decode(mq[0], 32, c_imm, c_fmt, c_ill);
        checkOutput("out_imm32", 64'(out_imm32), c_imm);
        checkOutput("out_fmt32", 64'(out_fmt32), 64'(c_fmt));
        checkOutput("out_illegal32", 64'(out_illegal32), 64'(c_ill));
      end
    end
  end

  logic [31:0] b2b_word[4] = '{32'hB4000020, 32'h17FFFFFF, 32'h913FFC00, 32'hD2D7DDE0};
  logic [63:0] b2b_imm[4]  = '{64'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFF, 64'h0000_BEEF_0000_0000};
  logic [2:0]  b2b_fmt[4]  = '{3'd3, 3'd4, 3'd2, 3'd5};

  initial begin
    $display("[TB] start");
    applyStimulus(32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid64), 64'h0);
    checkOutput("rst_in_ready", 64'(in_ready64), 64'h1);
    checkOutput("rst_err_count", 64'(err_count64), 64'h0);
    checkOutput("rst_out_imm", out_imm64, 64'h0);
    checkOutput("rst_out_fmt", 64'(out_fmt64), 64'(FMT_NONE));
    checkOutput("rst_out_illegal", 64'(out_illegal64), 64'h0);
    reset = 1'b1;

    // Single LDUR
    applyStimulus(32'hF85F8000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("ldur_valid", 64'(out_valid64), 64'h1);
    checkOutput("ldur_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("ldur_fmt", 64'(out_fmt64), 64'(FMT_D));
    checkOutput("ldur_illegal", 64'(out_illegal64), 64'h0);
    checkOutput("ldur_imm32", 64'(out_imm32), 64'hFFFF_FFF8);

    // Back-to-back, one word per cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(b2b_word[i], 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("b2b_valid", 64'(out_valid64), 64'h1);
      checkOutput("b2b_imm64", out_imm64, b2b_imm[i]);
      checkOutput("b2b_fmt64", 64'(out_fmt64), 64'(b2b_fmt[i]));
    end
    checkOutput("movz32_illegal", 64'(out_illegal32), 64'h1);
    checkOutput("movz32_imm", 64'(out_imm32), 64'h0);
    checkOutput("movz32_fmt", 64'(out_fmt32), 64'(FMT_IW));
    applyStimulus(32'h0, 1'b0, 1'b1);
    @(negedge clk);

    // Stall: three words offered, two taken, then drain in order
    applyStimulus(32'hB4000020, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h913FFC00, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stall_in_ready", 64'(in_ready64), 64'h0);
    applyStimulus(32'h17FFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stall_in_ready2", 64'(in_ready64), 64'h0);
    checkOutput("stall_head", out_imm64, 64'h4);
    applyStimulus(32'h17FFFFFF, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("drain_second", out_imm64, 64'hFFF);
    checkOutput("drain_in_ready", 64'(in_ready64), 64'h1);
    @(negedge clk);
    checkOutput("drain_third", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(32'h0, 1'b0, 1'b1);
    @(negedge clk);

    // Illegal word and counter saturation
    applyStimulus(32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("illegal_flag", 64'(out_illegal64), 64'h1);
    checkOutput("illegal_fmt", 64'(out_fmt64), 64'(FMT_NONE));
    checkOutput("illegal_imm", out_imm64, 64'h0);
    checkOutput("illegal_count", 64'(err_count64), 64'h1);
    repeat (300) @(negedge clk);
    checkOutput("sat_count64", 64'(err_count64), 64'd255);
    checkOutput("sat_count32", 64'(err_count32), 64'd255);
    applyStimulus(32'h0, 1'b0, 1'b1);

    // Randomized traffic with varying backpressure
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int blk = 0; blk < 30; blk++) begin
      int ready_pct;
      ready_pct = $urandom_range(10, 100);
      for (int c = 0; c < 100; c++) begin
        applyStimulus(rand_instr(), $urandom_range(0, 3) != 0,
                      $urandom_range(1, 100) <= ready_pct);
        @(negedge clk);
      end
    end

    // Asynchronous reset while both registers hold words
    applyStimulus(32'h0, 1'b0, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(32'h0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("full_in_ready", 64'(in_ready64), 64'h0);
    checkOutput("full_err_count", 64'(err_count64), 64'h2);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_out_valid", 64'(out_valid64), 64'h0);
    checkOutput("async_in_ready", 64'(in_ready64), 64'h1);
    checkOutput("async_err_count", 64'(err_count64), 64'h0);
    checkOutput("async_in_ready32", 64'(in_ready32), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      applyStimulus(rand_instr(), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_imm_gen_pipe

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the LEGv8 datapath. It decodes every immediate-bearing format the processor will support: D, I, CB, B and IW (MOVZ). It sign-, zero- or shift-extends the field to N bits and delivers the result through a valid/ready stage with a 2-entry skid buffer, so it can sit between fetch/decode and the register-read stage of the pipelined core. It also flags and counts unsupported opcodes.

## Interface
- N, 64: datapath width. Legal values are 32 and 64.
- ERR_W, 8: width of the unsupported-opcode counter.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction on in_instr is valid.
- in_ready  out  1  block accepts in_instr this cycle.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  out_imm/out_fmt/out_illegal are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  N  extended immediate.
- out_fmt  out  3  imm_pkg::fmt_e format tag.
- out_illegal  out  1  opcode is not in the supported set.
- err_count  out  ERR_W  saturating count of accepted illegal instructions.

## Operation
- Opcode match, with the first match winning:
  - LDUR 11111000010 / STUR 11111000000 on [31:21] → FMT_D: sign-extend [20:12].
  - CBZ 10110100 / CBNZ 10110101 on [31:24] → FMT_CB: sign-extend {[23:5], 2'b00}.
  - B 000101 / BL 100101 on [31:26] → FMT_B: sign-extend {[25:0], 2'b00}.
  - ADDI 1001000100 / SUBI 1101000100 on [31:22] → FMT_I: zero-extend [21:10].
  - MOVZ 110100101 on [31:23] → FMT_IW: [20:5] zero-extended, shifted left by 16·[22:21].
- No match → FMT_NONE, out_imm = 0, out_illegal = 1.
- MOVZ with N=32 and hw ≥ 2 → FMT_IW, out_imm = 0, out_illegal = 1.
- All extension is computed at width N. Shift bits beyond N are discarded.
- err_count increments by 1 on every accepted transfer (in_valid & in_ready) whose decode is illegal. It saturates at 2^ERR_W−1 and never wraps.

## Timing
- Transfer rule: a transfer occurs when valid & ready on the same edge. Once out_valid is asserted, out_valid and out data hold until out_ready.
- Latency: 1 cycle. An instruction accepted at edge k appears on out_* after edge k when the output register is free.
- Skid buffer:
  - in_ready is a registered signal equal to "skid register empty".
  - If out_valid & !out_ready and a new input is accepted, the decoded word goes into the skid register and in_ready drops on the next cycle.
  - When the output drains, the skid content moves to the output register on the same edge, and in_ready rises on the next cycle.
- Throughput: 1 instruction per cycle with no bubbles while out_ready is held high.
- Order: outputs are strictly FIFO. The skid entry always leaves before any new input.
- Simultaneous accept and drain with the skid empty: the output register loads the new word and out_valid stays 1.
- Reset is asynchronous, active-low, and valid at any time, including mid-stall. Reset values:
  - out_valid = 0
  - out_imm = 0
  - out_fmt = FMT_NONE
  - out_illegal = 0
  - in_ready = 1
  - skid register empty
  - err_count = 0
- In-flight words are dropped on reset. The first acceptance after reset is on the first edge with reset high.

## Structure
- imm_pkg holds:
  - typedef enum logic [2:0] fmt_e {FMT_NONE, FMT_D, FMT_I, FMT_CB, FMT_B, FMT_IW}
  - opcode localparams: OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B, OP_BL, OP_ADDI, OP_SUBI, OP_MOVZ
  - packed struct imm_res_t {imm, fmt, illegal}
- Sub-module imm_decode (combinational, parameter N): maps in_instr to imm_res_t.
- imm_gen_pipe holds the output register, skid register and error counter.

## Test plan
- LDUR 0xF85F8000, out_ready = 1 → next cycle: out_imm = 0xFFFF_FFFF_FFFF_FFF8, FMT_D, illegal = 0.
- Back-to-back sequence CBZ 0xB4000020, B 0x17FFFFFF, ADDI 0x913FFC00, MOVZ 0xD2D7DDE0 with out_ready = 1 → four consecutive outputs:
  - 0x4
  - 0xFFFF_FFFF_FFFF_FFFC
  - 0xFFF
  - 0x0000_BEEF_0000_0000
- Each output must carry the correct fmt tag.
- Hold out_ready = 0 while sending 3 valid words → 2 accepted, then in_ready = 0. Release out_ready → outputs arrive in order, then in_ready returns to 1.
- Instruction 0x00000000 → FMT_NONE, out_imm = 0, illegal = 1, err_count 0 → 1. Preload 255 illegals with ERR_W = 8 → count stays 255.
- N=32 instance:
  - MOVZ hw = 2 → illegal = 1, out_imm = 0.
  - LDUR 0xF85F8000 → 0xFFFF_FFF8.
- Assert reset during a stall with both registers full → out_valid = 0, in_ready = 1 and err_count = 0 immediately, without waiting for a clock edge.
